and_cell_arbiter: RTL and testbench
===================================

# and_cell_arbiter

Round-robin arbiter and sequencer that shares one registered AND datapath (AND cell feeding a D flip-flop cell, one clock of latency) among NREQ requesters. It accepts one request at a time and drives the shared cell's operand inputs. It captures the registered result after the cell's latency and returns it tagged with the requester ID. It sits between the requester blocks and the gate-level AND/DFF datapath; the datapath cells stay external and are connected through the `cell_*` ports.

## Interface
- `NREQ`, default 4: number of requesters; power of two, 2..8.
- `WIDTH`, default 1: operand/result width; the shared datapath is WIDTH bit-slices of AND+DFF.
- `IDW`, default 2: requester ID width; must equal log2(NREQ).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: request per requester; bit i belongs to requester i.
- `op_a` input NREQ*WIDTH: operand A; slice i is `[i*WIDTH +: WIDTH]`.
- `op_b` input NREQ*WIDTH: operand B; same slicing as `op_a`.
- `gnt` output NREQ: one-hot, one-cycle pulse meaning the request was accepted and its operands were sampled.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `cell_in0` output WIDTH: drives the in0 inputs of the shared AND cells.
- `cell_in1` output WIDTH: drives the in1 inputs of the shared AND cells.
- `cell_out` input WIDTH: from the shared DFF cells; equals `cell_in0 & cell_in1` as of the previous edge.
- `rsp_valid` output 1: one-cycle pulse meaning a result is available.
- `rsp_id` output IDW: index of the requester that owns the result.
- `rsp_data` output WIDTH: the AND result.

## Operation
- The FSM has three states, reset state IDLE:
  - IDLE → ISSUE on any edge where `req != 0`; stays in IDLE otherwise.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE unconditionally.
- Arbitration happens only on the IDLE edge.
  - The winner is the first set `req` bit found by searching from `ptr` upward, wrapping from NREQ-1 to 0.
  - `ptr` is an internal IDW-bit register, reset 0.
  - On grant, `ptr` is set to winner+1 mod NREQ; wrap-around from NREQ-1 gives 0.
- The grant edge (IDLE→ISSUE) registers four things:
  - `gnt` = one-hot(winner).
  - `cur_id` = winner.
  - `cell_in0` = winner's `op_a` slice, sampled at that edge.
  - `cell_in1` = winner's `op_b` slice, sampled at that edge.
- `cell_in0`/`cell_in1` hold their values until the next grant. The cell keeps re-registering them; this is harmless.
- Sampling `cell_out`:
  - The ISSUE→WAIT edge is the edge on which the external DFF captures the AND result.
  - The WAIT→IDLE edge registers `rsp_data` = `cell_out`, `rsp_id` = `cur_id` and `rsp_valid` = 1.
  - `cell_out` is ignored in every other state, so an unreset DFF cell (X before its first capture) never reaches `rsp_data` before the first transaction.
- `rsp_valid` deasserts the following cycle unless a new response is registered. Back-to-back responses are at least 3 cycles apart, so in practice it always deasserts.
- Requester rules:
  - Hold `req` and the operands stable until `gnt` is seen, then drop `req`.
  - `req` is ignored outside IDLE. A `req` still high at the next IDLE edge is a new request.
  - Requests not granted stay pending (held by the requester) and are served in round-robin order.
- Reset, including mid-transaction:
  - Outputs: `gnt`=0, `busy`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `cell_in0`=0, `cell_in1`=0.
  - Internal: state IDLE, `ptr`=0, `cur_id`=0.
  - An in-flight transaction is discarded: no `rsp_valid` and no `gnt` follow.
  - A `req` high while `rst`=1 is not granted until the first edge after `rst` falls.

## Timing
- Edge E0 (IDLE, `req` seen):
  - Cycle after E0: `gnt` pulse, `cell_in*` valid, `busy`=1, state ISSUE.
- Edge E1:
  - Cycle after E1: `cell_out` valid, state WAIT, `gnt`=0.
- Edge E2:
  - Cycle after E2: `rsp_valid`=1, `rsp_id`, `rsp_data` valid, `busy`=0, state IDLE.
  - An arbitration may occur on the edge ending this cycle.
- Latency is 3 cycles from the sampled `req` to `rsp_valid`.
- Throughput is one operation per 3 cycles under continuous requests.
- `gnt` always precedes its own `rsp_valid` by exactly 2 cycles.

## Test plan
- Reset check: after reset, all outputs are 0 and `busy`=0. With `WIDTH`=1, `req`=4'b0010, `op_a`[1]=1, `op_b`[1]=1 → `gnt`=0010 one cycle later, then `rsp_valid`=1, `rsp_id`=1, `rsp_data`=1 three cycles after the request edge.
- Truth table: requester 0 issues (0,0), (0,1), (1,0), (1,1) in sequence → `rsp_data` 0, 0, 0, 1, each with `rsp_id`=0, and `rsp_valid` pulses exactly one cycle each.
- Round-robin: `req`=4'b1111 held continuously, with requesters dropping `req` after their `gnt` and re-raising it 1 cycle later → grant order 0, 1, 2, 3, 0; successive `gnt` pulses are exactly 3 cycles apart.
- Wrap and skip: `ptr`=3 after a grant to requester 2, then `req`=4'b0011 → grant to 0 (wrap from 3); the next grant goes to 1.
- `req` ignored while busy: `req[2]` rises in the ISSUE cycle of a requester-0 transaction and is held → no `gnt[2]` until the next IDLE edge, then `gnt`=0100 in the cycle after `rsp_valid` for requester 0.
- Reset mid-operation: assert `rst` for one cycle during WAIT → no `rsp_valid`; all outputs and `ptr` return to 0. With `req`=4'b1000 held through reset, the first grant after reset is to requester 3.

Source files
------------

// File: rtl/and_cell_arbiter_if.sv
// and_cell_arbiter_if: requester, response and shared-cell signals of the AND cell arbiter
interface and_cell_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      cell_in0;
  logic [WIDTH-1:0]      cell_in1;
  logic [WIDTH-1:0]      cell_out;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  modport master (
    output req, op_a, op_b, cell_out,
    input  gnt, busy, cell_in0, cell_in1, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req, op_a, op_b, cell_out,
    output gnt, busy, cell_in0, cell_in1, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/and_cell_arbiter.sv
// and_cell_arbiter: round-robin sequencer sharing one registered AND datapath among requesters
module and_cell_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  parameter int IDW   = 2
) (
  input logic clk,
  input logic rst,
  and_cell_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, cur_id_q, cur_id_d, rsp_id_q, rsp_id_d, win;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] in0_q, in0_d, in1_q, in1_d, rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d, grant;
  // pick the first requester at or after ptr, wrapping; lowest offset is written last so it wins
  always_comb begin
    win = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) win = bus.req[ptr_q + IDW'(k)] ? ptr_q + IDW'(k) : win;
  end
  // IDLE -> ISSUE on any request, then a fixed walk through WAIT back to IDLE
  always_comb begin
    state_d = state_q == IDLE ? (|bus.req ? ISSUE : IDLE) : state_q == ISSUE ? WAIT : IDLE;
  end
  // grant bookkeeping, operand capture and response capture once the cell has registered
  always_comb begin
    grant       = state_q == IDLE && |bus.req;
    gnt_d       = grant ? NREQ'(1) << win : '0;
    ptr_d       = grant ? win + IDW'(1) : ptr_q;
    cur_id_d    = grant ? win : cur_id_q;
    in0_d       = grant ? bus.op_a[win*WIDTH +: WIDTH] : in0_q;
    in1_d       = grant ? bus.op_b[win*WIDTH +: WIDTH] : in1_q;
    rsp_valid_d = state_q == WAIT;
    rsp_id_d    = rsp_valid_d ? cur_id_q : rsp_id_q;
    rsp_data_d  = rsp_valid_d ? bus.cell_out : rsp_data_q;
  end
  // state and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      gnt_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.cell_in0  = in0_q;
  assign bus.cell_in1  = in1_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_and_cell_arbiter.sv
// tb_and_cell_arbiter: scoreboard bench for the round-robin AND cell arbiter
module tb_and_cell_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cell_q;
  int checks = 0, passes = 0, cyc = 0;
  logic [2:0] exp_q[$];
  logic [2:0] rsp_e;
  int glog[$], gcyc[$];
  logic [3:0] persist = '0, rearm = '0;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  and_cell_arbiter_if #(.NREQ(4), .WIDTH(1), .IDW(2)) bus ();
  and_cell_arbiter #(.NREQ(4), .WIDTH(1), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cell_q <= bus.cell_in0 & bus.cell_in1;
  assign bus.cell_out = cell_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  always @(negedge clk) if (bus.rsp_valid) begin
    if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
    else begin
      rsp_e = exp_q.pop_front();
      chk("rsp_id", 32'(bus.rsp_id), 32'(rsp_e[2:1]));
      chk("rsp_data", 32'(bus.rsp_data), 32'(rsp_e[0]));
    end
  end

  task automatic step();
    int id;
    @(posedge clk);
    #1;
    cyc++;
    bus.req = bus.req | rearm;
    rearm = '0;
    if (bus.gnt != 0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) id = i;
      chk("gnt_onehot", $countones(bus.gnt), 1);
      exp_q.push_back({id[1:0], bus.op_a[id] & bus.op_b[id]});
      glog.push_back(id);
      gcyc.push_back(cyc);
      rearm = bus.gnt & persist;
      bus.req = bus.req & ~bus.gnt;
    end
  endtask

  task automatic wait_gnt(input int exp_id, input string tag);
    int n;
    n = glog.size();
    for (int k = 0; k < 20 && glog.size() == n; k++) step();
    if (glog.size() == n) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk(tag, glog[n], exp_id);
      chk({tag, "_busy"}, 32'(bus.busy), 1);
    end
  endtask

  task automatic txn(input logic [3:0] mask, input int exp_id, input string tag);
    bus.req = bus.req | mask;
    wait_gnt(exp_id, tag);
    step();
    step();
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_idle"}, 32'(bus.busy), 0);
    step();
    chk({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_cell_in0"}, 32'(bus.cell_in0), 0);
    chk({tag, "_cell_in1"}, 32'(bus.cell_in1), 0);
  endtask

  initial begin
    bus.req = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_zero("reset");
    bus.op_a = 4'b0010;
    bus.op_b = 4'b0010;
    txn(4'b0010, 1, "first");
    chk("first_cell_in0", 32'(bus.cell_in0), 1);
    chk("first_cell_in1", 32'(bus.cell_in1), 1);
    for (int t = 0; t < 4; t++) begin
      bus.op_a[0] = t[1];
      bus.op_b[0] = t[0];
      txn(4'b0001, 0, "truth");
    end
    bus.op_a = 4'b1111;
    bus.op_b = 4'b1010;
    txn(4'b1000, 3, "to_ptr0");
    begin
      int n0;
      n0 = glog.size();
      persist = 4'b1111;
      bus.req = 4'b1111;
      for (int k = 0; k < 40 && glog.size() < n0 + 5; k++) step();
      persist = '0;
      rearm = '0;
      bus.req = '0;
      chk("rr_count", glog.size() - n0, 5);
      for (int i = 0; i < 5 && n0 + i < glog.size(); i++) begin
        chk("rr_order", glog[n0+i], rr_exp[i]);
        if (i > 0) chk("rr_gap", gcyc[n0+i] - gcyc[n0+i-1], 3);
      end
    end
    repeat (4) step();
    bus.op_a = 4'b0111;
    bus.op_b = 4'b0011;
    txn(4'b0100, 2, "to_ptr3");
    bus.req = 4'b0011;
    wait_gnt(0, "wrap");
    wait_gnt(1, "skip");
    repeat (3) step();
    bus.req = 4'b0001;
    wait_gnt(0, "busy_own");
    bus.req[2] = 1'b1;
    step();
    chk("busy_ign_issue", 32'(bus.gnt), 0);
    step();
    chk("busy_ign_wait", 32'(bus.gnt), 0);
    chk("busy_ign_rsp", 32'(bus.rsp_valid), 1);
    step();
    chk("busy_ign_gnt", 32'(bus.gnt), 4'b0100);
    repeat (3) step();
    bus.req = 4'b0010;
    wait_gnt(1, "midrst_own");
    step();
    rst = 1'b1;
    bus.req = 4'b1000;
    exp_q.delete();
    step();
    chk_zero("midrst");
    rst = 1'b0;
    step();
    chk("midrst_gnt", 32'(bus.gnt), 4'b1000);
    repeat (3) step();
    txn(4'b0010, 1, "pre_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b0110;
    wait_gnt(1, "ptr_rst");
    wait_gnt(2, "ptr_rst_next");
    repeat (4) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
